eth_sram_bridge: RTL and testbench

Packet-to-SRAM command bridge that replaces the single-shot packet interface with a handshaked, parametrised engine. It accepts command packets of {header, address, data} over a valid/ready link, performs single writes, single reads and burst reads against the on-chip SRAM, and returns response packets under output backpressure. It adds configurable read latency, write acknowledgements, range checking, error responses and an error counter.

---
 rtl/eth_sram_pkg.sv | 20 ++
 rtl/eth_resp_slot.sv | 27 ++
 rtl/eth_sram_bridge.sv | 194 +++++++++++++++++++
 tb/tb_eth_sram_bridge.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_sram_pkg.sv
// Shared opcodes, FSM state encoding and header-field widths for the
// packet-to-SRAM command bridge.
package eth_sram_pkg;

  localparam int HDR_W = 8;
  localparam int LEN_W = 8;

  localparam logic [HDR_W-1:0] OP_READ  = 8'hAA;
  localparam logic [HDR_W-1:0] OP_WRITE = 8'hBB;
  localparam logic [HDR_W-1:0] OP_BURST = 8'hCC;
  localparam logic [HDR_W-1:0] OP_ERROR = 8'hEE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/eth_resp_slot.sv
// Single-entry response register: a loaded packet stays valid and stable
// until the downstream side takes it.
module eth_resp_slot #(
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/eth_sram_bridge.sv
// Handshaked command engine: decodes {header, addr, data} packets into SRAM
// writes, reads and burst reads, and returns responses under backpressure.
module eth_sram_bridge
  import eth_sram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int PACKET_WIDTH = 8 + ADDR_WIDTH + DATA_WIDTH,
  parameter int MEM_DEPTH    = 256,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 16,
  parameter int ACK_WRITES   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PACKET_WIDTH-1:0] packet_in,
  input  logic                    packet_valid,
  output logic                    packet_ready,
  output logic [PACKET_WIDTH-1:0] packet_out,
  output logic                    packet_out_valid,
  input  logic                    packet_out_ready,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_data_in,
  output logic                    sram_write_en,
  output logic                    sram_read_en,
  input  logic [DATA_WIDTH-1:0]   sram_data_out,
  output logic [15:0]             error_count
);

  // Burst end address is formed wide enough that addr + L - 1 never wraps.
  localparam int END_W = ((ADDR_WIDTH > LEN_W) ? ADDR_WIDTH : LEN_W) + 1;
  localparam logic [END_W-1:0] DEPTH_E  = END_W'(MEM_DEPTH);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BURST);
  localparam logic [1:0]       LAT_INIT = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t                  state, state_nxt;
  logic                    packet_ready_nxt;
  logic [ADDR_WIDTH-1:0]   sram_addr_nxt;
  logic [DATA_WIDTH-1:0]   sram_data_in_nxt;
  logic                    sram_write_en_nxt, sram_read_en_nxt;
  logic [15:0]             error_count_nxt;
  logic [HDR_W-1:0]        cmd_hdr, cmd_hdr_nxt;
  logic [LEN_W-1:0]        beat, beat_nxt, burst_len, burst_len_nxt;
  logic [1:0]              lat_cnt, lat_cnt_nxt;
  logic                    slot_load;
  logic [PACKET_WIDTH-1:0] slot_pkt;

  logic [HDR_W-1:0]      in_hdr;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_data;
  logic [LEN_W-1:0]      in_len;
  logic [END_W-1:0]      burst_end;
  logic                  is_read, is_write, is_burst, cmd_error, accept;

  assign in_hdr    = packet_in[PACKET_WIDTH-1 -: HDR_W];
  assign in_addr   = packet_in[DATA_WIDTH +: ADDR_WIDTH];
  assign in_data   = packet_in[DATA_WIDTH-1:0];
  assign in_len    = in_data[LEN_W-1:0];
  assign is_read   = (in_hdr == OP_READ);
  assign is_write  = (in_hdr == OP_WRITE);
  assign is_burst  = (in_hdr == OP_BURST);
  assign burst_end = END_W'(in_addr) + END_W'(in_len) - END_W'(1);
  assign cmd_error = !(is_read || is_write || is_burst) ||
                     (END_W'(in_addr) >= DEPTH_E) ||
                     (is_burst && ((in_len == '0) || (in_len > MAX_LEN) ||
                                   (burst_end >= DEPTH_E)));
  assign accept    = packet_valid && packet_ready;

  eth_resp_slot #(.WIDTH(PACKET_WIDTH)) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (slot_load),
    .load_data (slot_pkt),
    .ready     (packet_out_ready),
    .data      (packet_out),
    .valid     (packet_out_valid)
  );

  always_comb begin
    state_nxt         = state;
    packet_ready_nxt  = packet_ready;
    sram_addr_nxt     = sram_addr;
    sram_data_in_nxt  = sram_data_in;
    sram_write_en_nxt = 1'b0;
    sram_read_en_nxt  = 1'b0;
    error_count_nxt   = error_count;
    cmd_hdr_nxt       = cmd_hdr;
    beat_nxt          = beat;
    burst_len_nxt     = burst_len;
    lat_cnt_nxt       = lat_cnt;
    slot_load         = 1'b0;
    slot_pkt          = '0;
    case (state)
      ST_IDLE: begin
        packet_ready_nxt = !accept;
        if (accept) begin
          beat_nxt      = '0;
          burst_len_nxt = is_burst ? in_len : '0;
          if (cmd_error) begin
            // Error header is latched so the response never continues as a burst.
            cmd_hdr_nxt     = OP_ERROR;
            slot_load       = 1'b1;
            slot_pkt        = {OP_ERROR, in_addr, DATA_WIDTH'(in_hdr)};
            error_count_nxt = sat_inc(error_count);
            state_nxt       = ST_RESP;
          end else begin
            cmd_hdr_nxt       = in_hdr;
            sram_addr_nxt     = in_addr;
            sram_write_en_nxt = is_write;
            sram_read_en_nxt  = !is_write;
            if (is_write) sram_data_in_nxt = in_data;
            state_nxt         = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (cmd_hdr == OP_WRITE) begin
          if (ACK_WRITES != 0) begin
            slot_load = 1'b1;
            slot_pkt  = {OP_WRITE, sram_addr, sram_data_in};
            state_nxt = ST_RESP;
          end else begin
            packet_ready_nxt = 1'b1;
            state_nxt        = ST_IDLE;
          end
        end else if (READ_LATENCY == 1) begin
          slot_load = 1'b1;
          slot_pkt  = {cmd_hdr, sram_addr, sram_data_out};
          state_nxt = ST_RESP;
        end else begin
          lat_cnt_nxt = LAT_INIT;
          state_nxt   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_cnt == 2'd0) begin
          slot_load = 1'b1;
          slot_pkt  = {cmd_hdr, sram_addr, sram_data_out};
          state_nxt = ST_RESP;
        end else begin
          lat_cnt_nxt = lat_cnt - 2'd1;
        end
      end
      ST_RESP: begin
        if (packet_out_valid && packet_out_ready) begin
          if ((cmd_hdr == OP_BURST) && ((beat + 8'd1) != burst_len)) begin
            beat_nxt         = beat + 8'd1;
            sram_addr_nxt    = sram_addr + ADDR_WIDTH'(1);
            sram_read_en_nxt = 1'b1;
            state_nxt        = ST_ISSUE;
          end else begin
            beat_nxt         = '0;
            packet_ready_nxt = 1'b1;
            state_nxt        = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      packet_ready  <= 1'b0;
      sram_addr     <= '0;
      sram_data_in  <= '0;
      sram_write_en <= 1'b0;
      sram_read_en  <= 1'b0;
      error_count   <= '0;
      cmd_hdr       <= '0;
      beat          <= '0;
      burst_len     <= '0;
      lat_cnt       <= '0;
    end else begin
      state         <= state_nxt;
      packet_ready  <= packet_ready_nxt;
      sram_addr     <= sram_addr_nxt;
      sram_data_in  <= sram_data_in_nxt;
      sram_write_en <= sram_write_en_nxt;
      sram_read_en  <= sram_read_en_nxt;
      error_count   <= error_count_nxt;
      cmd_hdr       <= cmd_hdr_nxt;
      beat          <= beat_nxt;
      burst_len     <= burst_len_nxt;
      lat_cnt       <= lat_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_eth_sram_bridge.sv
// Directed bench for eth_sram_bridge: default build, a READ_LATENCY=3 build
// and an ACK_WRITES=0 build, each with its own SRAM model.
module tb_eth_sram_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A: default parameters
  logic [47:0] a_pkt = '0, a_out;
  logic        a_valid = 1'b0, a_ready, a_out_valid, a_out_ready = 1'b0;
  logic [7:0]  a_addr;
  logic [31:0] a_din, a_dout;
  logic        a_we, a_re;
  logic [15:0] a_err;
  logic [31:0] mem_a [256];

  // Instance B: READ_LATENCY = 3
  logic [47:0] b_pkt = '0, b_out;
  logic        b_valid = 1'b0, b_ready, b_out_valid, b_out_ready = 1'b0;
  logic [7:0]  b_addr;
  logic [31:0] b_din, b_dout, b_d1, b_d2;
  logic        b_we, b_re, b_rv1, b_rv2;
  logic [15:0] b_err;
  logic [31:0] mem_b [256];

  // Instance C: ACK_WRITES = 0
  logic [47:0] c_pkt = '0, c_out;
  logic        c_valid = 1'b0, c_ready, c_out_valid, c_out_ready = 1'b1;
  logic [7:0]  c_addr;
  logic [31:0] c_din;
  logic [31:0] c_dout = '0;
  logic        c_we, c_re;
  logic [15:0] c_err;

  int a_we_cnt = 0, a_re_cnt = 0, a_viol = 0, c_we_cnt = 0, c_vld_cnt = 0;

  eth_sram_bridge u_a (
    .clk(clk), .rst_n(rst_n), .packet_in(a_pkt), .packet_valid(a_valid),
    .packet_ready(a_ready), .packet_out(a_out), .packet_out_valid(a_out_valid),
    .packet_out_ready(a_out_ready), .sram_addr(a_addr), .sram_data_in(a_din),
    .sram_write_en(a_we), .sram_read_en(a_re), .sram_data_out(a_dout),
    .error_count(a_err));

  eth_sram_bridge #(.READ_LATENCY(3)) u_b (
    .clk(clk), .rst_n(rst_n), .packet_in(b_pkt), .packet_valid(b_valid),
    .packet_ready(b_ready), .packet_out(b_out), .packet_out_valid(b_out_valid),
    .packet_out_ready(b_out_ready), .sram_addr(b_addr), .sram_data_in(b_din),
    .sram_write_en(b_we), .sram_read_en(b_re), .sram_data_out(b_dout),
    .error_count(b_err));

  eth_sram_bridge #(.ACK_WRITES(0)) u_c (
    .clk(clk), .rst_n(rst_n), .packet_in(c_pkt), .packet_valid(c_valid),
    .packet_ready(c_ready), .packet_out(c_out), .packet_out_valid(c_out_valid),
    .packet_out_ready(c_out_ready), .sram_addr(c_addr), .sram_data_in(c_din),
    .sram_write_en(c_we), .sram_read_en(c_re), .sram_data_out(c_dout),
    .error_count(c_err));

  // SRAM A: data valid while read_en is high (latency 1); garbage otherwise
  assign a_dout = a_re ? mem_a[a_addr] : 32'hBADBAD00;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= 32'(i);
    end else if (a_we) begin
      mem_a[a_addr] <= a_din;
    end
  end

  // SRAM B: data appears two edges after the edge that samples read_en
  assign b_dout = b_rv2 ? b_d2 : 32'hBADBAD00;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= 32'(i);
    end
    b_rv1 <= b_re;
    b_rv2 <= b_rv1;
    b_d1  <= mem_b[b_addr];
    b_d2  <= b_d1;
  end

  always @(posedge clk) begin
    if (a_we) a_we_cnt <= a_we_cnt + 1;
    if (a_re) a_re_cnt <= a_re_cnt + 1;
    if (a_out_valid && (a_we || a_re)) a_viol <= a_viol + 1;
    if (c_we) c_we_cnt <= c_we_cnt + 1;
    if (c_out_valid) c_vld_cnt <= c_vld_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [47:0] p);
    int n;
    n = 0;
    a_pkt   = p;
    a_valid = 1'b1;
    while (!a_ready && n < 50) begin
      tick();
      n++;
    end
    chk("a_ready_before_accept", a_ready, 1);
    tick();
    a_valid = 1'b0;
  endtask

  task automatic wait_a(input string tag);
    int n;
    n = 0;
    while (!a_out_valid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, a_out_valid, 1);
  endtask

  logic [47:0] exp_pkt;
  logic [47:0] err_in  [4];
  logic [47:0] err_exp [4];
  int re_snap, we_snap, n;

  initial begin
    err_in[0] = {8'h55, 8'h00, 32'd0};  err_exp[0] = {8'hEE, 8'h00, 32'h55};
    err_in[1] = {8'hCC, 8'hFE, 32'd4};  err_exp[1] = {8'hEE, 8'hFE, 32'hCC};
    err_in[2] = {8'hCC, 8'h30, 32'd0};  err_exp[2] = {8'hEE, 8'h30, 32'hCC};
    err_in[3] = {8'hCC, 8'h30, 32'd17}; err_exp[3] = {8'hEE, 8'h30, 32'hCC};

    // Reset values
    #3 rst_n = 1'b0;
    #1;
    chk("rst_ready", a_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out", a_out, 0);
    chk("rst_strobes", {a_we, a_re}, 0);
    chk("rst_err", a_err, 0);
    tick(); tick(); tick();
    rst_n = 1'b1;
    chk("rst_release_ready_low", a_ready, 0);
    tick();
    chk("ready_after_release", a_ready, 1);

    // Write with ack, then read back
    send_a({8'hBB, 8'h10, 32'hDEADBEEF});
    chk("wr_strobe", a_we, 1);
    chk("wr_addr", a_addr, 8'h10);
    chk("wr_data", a_din, 32'hDEADBEEF);
    chk("wr_ready_low", a_ready, 0);
    chk("wr_no_resp_yet", a_out_valid, 0);
    tick();
    chk("wr_strobe_off", a_we, 0);
    chk("ack_valid", a_out_valid, 1);
    chk("ack_pkt", a_out, {8'hBB, 8'h10, 32'hDEADBEEF});
    chk("wr_pulse_count", a_we_cnt, 1);
    a_out_ready = 1'b1;
    tick();
    chk("ack_taken", a_out_valid, 0);
    chk("ready_after_ack", a_ready, 1);
    send_a({8'hAA, 8'h10, 32'd0});
    chk("rd_strobe", a_re, 1);
    chk("rd_addr", a_addr, 8'h10);
    chk("rd_not_yet", a_out_valid, 0);
    tick();
    chk("rd_valid", a_out_valid, 1);
    chk("rd_pkt", a_out, {8'hAA, 8'h10, 32'hDEADBEEF});
    tick();
    chk("rd_taken", a_out_valid, 0);

    // Burst of 4 with 3 stall cycles per beat
    a_out_ready = 1'b0;
    re_snap = a_re_cnt;
    send_a({8'hCC, 8'h20, 32'd4});
    for (int i = 0; i < 4; i++) begin
      wait_a("burst_valid");
      exp_pkt = {8'hCC, 8'(32 + i), 32'(32 + i)};
      chk("burst_pkt", a_out, exp_pkt);
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("burst_hold_pkt", a_out, exp_pkt);
        chk("burst_hold_valid", a_out_valid, 1);
        chk("burst_ready_low", a_ready, 0);
      end
      a_out_ready = 1'b1;
      tick();
      a_out_ready = 1'b0;
      chk("burst_released", a_out_valid, 0);
      if (i < 3) chk("burst_next_issue", a_re, 1);
      else       chk("burst_done_ready", a_ready, 1);
    end
    chk("burst_read_count", a_re_cnt - re_snap, 4);

    // Error commands
    a_out_ready = 1'b1;
    re_snap = a_re_cnt;
    we_snap = a_we_cnt;
    for (int i = 0; i < 4; i++) begin
      send_a(err_in[i]);
      chk("err_valid", a_out_valid, 1);
      chk("err_pkt", a_out, err_exp[i]);
      chk("err_no_strobe", {a_we, a_re}, 0);
      chk("err_count_step", a_err, i + 1);
      tick();
      chk("err_taken", a_out_valid, 0);
    end
    chk("err_no_reads", a_re_cnt - re_snap, 0);
    chk("err_no_writes", a_we_cnt - we_snap, 0);
    chk("err_count_final", a_err, 16'd4);

    // READ_LATENCY = 3
    b_pkt = {8'hAA, 8'h05, 32'd0};
    b_valid = 1'b1;
    n = 0;
    while (!b_ready && n < 20) begin tick(); n++; end
    chk("lat3_ready", b_ready, 1);
    tick();
    b_valid = 1'b0;
    chk("lat3_strobe", b_re, 1);
    tick();
    chk("lat3_not_yet_1", b_out_valid, 0);
    tick();
    chk("lat3_not_yet_2", b_out_valid, 0);
    tick();
    chk("lat3_valid", b_out_valid, 1);
    chk("lat3_pkt", b_out, {8'hAA, 8'h05, 32'h5});
    b_out_ready = 1'b1;
    tick();
    chk("lat3_taken", b_out_valid, 0);

    // ACK_WRITES = 0, back-to-back writes
    c_pkt = {8'hBB, 8'h40, 32'h11111111};
    c_valid = 1'b1;
    n = 0;
    while (!c_ready && n < 20) begin tick(); n++; end
    chk("noack_ready", c_ready, 1);
    tick();
    c_pkt = {8'hBB, 8'h41, 32'h22222222};
    n = 0;
    while (!c_ready && n < 20) begin tick(); n++; end
    tick();
    n++;
    c_valid = 1'b0;
    chk("noack_gap", n, 2);
    tick();
    tick();
    chk("noack_writes", c_we_cnt, 2);
    chk("noack_no_resp", c_vld_cnt, 0);

    // Reset during beat 2 of an 8-beat burst
    a_out_ready = 1'b0;
    send_a({8'hCC, 8'h00, 32'd8});
    for (int i = 0; i < 2; i++) begin
      wait_a("rb_beat_valid");
      a_out_ready = 1'b1;
      tick();
      a_out_ready = 1'b0;
    end
    wait_a("rb_beat2_valid");
    chk("rb_beat2_pkt", a_out, {8'hCC, 8'h02, 32'h2});
    re_snap = a_re_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("rb_out_valid", a_out_valid, 0);
    chk("rb_out", a_out, 0);
    chk("rb_ready", a_ready, 0);
    chk("rb_addr", a_addr, 0);
    chk("rb_din", a_din, 0);
    chk("rb_strobes", {a_we, a_re}, 0);
    chk("rb_err_clear", a_err, 0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("rb_no_more_reads", a_re_cnt - re_snap, 0);
    tick();
    chk("rb_ready_back", a_ready, 1);
    a_out_ready = 1'b1;
    send_a({8'hAA, 8'h01, 32'd0});
    chk("rb_rd_strobe", a_re, 1);
    tick();
    chk("rb_rd_valid", a_out_valid, 1);
    chk("rb_rd_pkt", a_out, {8'hAA, 8'h01, 32'h1});
    tick();
    chk("rb_rd_taken", a_out_valid, 0);

    chk("no_strobe_while_valid", a_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
